// File: rtl/ext_async_fifo_rd_ctrl.sv
// rtl/ext_async_fifo_rd_ctrl.sv - async FIFO read-side controller with 2-entry FWFT output buffer
module ext_async_fifo_rd_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  dstclk,
   input  logic                  dstrst_n,
   input  logic [ADDR_WIDTH:0]   wr_ptr_gray_sync,
   output logic [ADDR_WIDTH:0]   rd_ptr_gray,
   output logic                  ram_rd_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_empty,
   output logic [ADDR_WIDTH+1:0] rd_level,
   output logic                  ovf_err
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [PW-1:0]         rd_bin;
   logic [PW-1:0]         rd_bin_nx;
   logic [PW-1:0]         wr_bin;
   logic [PW-1:0]         ptr_diff;
   logic                  inflight;
   logic [1:0]            buf_cnt;
   logic [1:0]            occ;
   logic [1:0]            occ_after_pop;
   logic [DATA_WIDTH-1:0] buf0;
   logic [DATA_WIDTH-1:0] buf1;
   logic                  ram_empty;
   logic                  pop;
   logic                  push;

   // Each binary bit is the XOR of all Gray bits at and above it.
   always_comb begin
      wr_bin = '0;
      for (int i = 0; i < PW; i++) begin
         wr_bin[i] = ^(wr_ptr_gray_sync >> i);
      end
   end

   assign rd_bin_nx     = rd_bin + {{(PW-1){1'b0}}, 1'b1};
   assign ptr_diff      = wr_bin - rd_bin;
   assign ram_empty     = (rd_ptr_gray == wr_ptr_gray_sync);
   assign occ           = buf_cnt + {1'b0, inflight};
   assign rd_valid      = (buf_cnt != 2'd0);
   assign rd_data       = buf0;
   assign pop           = rd_valid & rd_ready;
   assign push          = inflight;
   assign occ_after_pop = occ - {1'b0, pop};
   // Issue only while the word can be guaranteed a buffer slot on arrival.
   assign ram_rd_en     = !ram_empty && (occ_after_pop < 2'd2);
   assign ram_rd_addr   = rd_bin[ADDR_WIDTH-1:0];
   assign rd_empty      = ram_empty && (occ == 2'd0);
   assign rd_level      = {1'b0, ptr_diff} + {{(PW-1){1'b0}}, occ};

   always_ff @(posedge dstclk or negedge dstrst_n) begin
      if (!dstrst_n) begin
         rd_bin      <= '0;
         rd_ptr_gray <= '0;
         inflight    <= 1'b0;
         buf_cnt     <= 2'd0;
         buf0        <= '0;
         buf1        <= '0;
         ovf_err     <= 1'b0;
      end else begin
         if (ram_rd_en) begin
            rd_bin      <= rd_bin_nx;
            rd_ptr_gray <= rd_bin_nx ^ (rd_bin_nx >> 1);
         end
         inflight <= ram_rd_en;
         if (ptr_diff > DEPTH) begin
            ovf_err <= 1'b1;
         end
         // buf0 is always the head; arrivals land behind whatever stays.
         case ({push, pop})
            2'b10: begin
               if (buf_cnt == 2'd0) buf0 <= ram_rd_data;
               else                 buf1 <= ram_rd_data;
               buf_cnt <= buf_cnt + 2'd1;
            end
            2'b01: begin
               buf0    <= buf1;
               buf_cnt <= buf_cnt - 2'd1;
            end
            2'b11: begin
               if (buf_cnt == 2'd1) begin
                  buf0 <= ram_rd_data;
               end else begin
                  buf0 <= buf1;
                  buf1 <= ram_rd_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
